// File: rtl/ser_tx_fifo.sv
// Parallel-to-serial feeder: buffers words in a small FIFO and shifts them out one bit per clock.
// Latency: a word accepted at edge E0 into an idle block drives its first bit after E1 and its last bit after E(WIDTH).
// Backpressure: listo drops when the FIFO is full; a write while listo=0 is dropped and sets sticky err_desborde.
module ser_tx_fifo #(
  parameter int   WIDTH     = 8,
  parameter int   DEPTH     = 4,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         dato_in,
  input  logic                     dato_valido,
  output logic                     listo,
  output logic                     s_out,
  output logic                     s_valido,
  output logic                     ocupado,
  output logic [$clog2(DEPTH):0]   conteo,
  output logic                     err_desborde
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [AW:0]   LLENO     = DEPTH[AW:0];
  localparam logic [BW-1:0] ULTIMO_IX = BW'(WIDTH - 1);

  typedef enum logic {INACTIVO, TRANSMITE} estado_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  estado_t          estado, estado_sig;
  logic [WIDTH-1:0] desp, desp_sig;
  logic [BW-1:0]    bits, bits_sig;
  logic             s_out_sig, s_valido_sig, ocupado_sig;
  logic             push, pop, hay_dato;
  logic [WIDTH-1:0] cabeza;

  // listo depends only on the registered count, so a same-cycle pop never raises it
  assign listo    = rst & (conteo != LLENO);
  assign hay_dato = (conteo != '0);
  assign push     = dato_valido & listo;
  assign cabeza   = mem[rd_ptr];

  // Next-state logic: load a word from the head, advance one bit, or fall back to idle
  always_comb begin
    estado_sig   = estado;
    desp_sig     = desp;
    bits_sig     = bits;
    s_out_sig    = s_out;
    s_valido_sig = s_valido;
    ocupado_sig  = ocupado;
    pop          = 1'b0;
    if (estado == TRANSMITE && bits != '0) begin
      // desp holds the bits not yet driven; take the next one
      if (MSB_FIRST != 0) begin
        s_out_sig = desp[WIDTH-1];
        desp_sig  = desp << 1;
      end else begin
        s_out_sig = desp[0];
        desp_sig  = desp >> 1;
      end
      bits_sig = bits - 1'b1;
    end else if (hay_dato) begin
      // idle with data waiting, or last bit just shown: reload with no gap cycle
      pop          = 1'b1;
      estado_sig   = TRANSMITE;
      s_valido_sig = 1'b1;
      ocupado_sig  = 1'b1;
      bits_sig     = ULTIMO_IX;
      if (MSB_FIRST != 0) begin
        s_out_sig = cabeza[WIDTH-1];
        desp_sig  = cabeza << 1;
      end else begin
        s_out_sig = cabeza[0];
        desp_sig  = cabeza >> 1;
      end
    end else begin
      estado_sig   = INACTIVO;
      s_out_sig    = IDLE_BIT;
      s_valido_sig = 1'b0;
      ocupado_sig  = 1'b0;
    end
  end

  // Serializer state and registered serial outputs; reset discards any partial word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado   <= INACTIVO;
      desp     <= '0;
      bits     <= '0;
      s_out    <= IDLE_BIT;
      s_valido <= 1'b0;
      ocupado  <= 1'b0;
    end else begin
      estado   <= estado_sig;
      desp     <= desp_sig;
      bits     <= bits_sig;
      s_out    <= s_out_sig;
      s_valido <= s_valido_sig;
      ocupado  <= ocupado_sig;
    end
  end

  // FIFO pointers, occupancy count and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      conteo       <= '0;
      err_desborde <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   conteo <= conteo + 1'b1;
        2'b01:   conteo <= conteo - 1'b1;
        default: conteo <= conteo;
      endcase
      if (dato_valido && !listo) err_desborde <= 1'b1;
    end
  end

  // Storage array needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dato_in;
  end

endmodule

// File: tb/tb_ser_tx_fifo.sv
module tb_ser_tx_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] dato_in = '0;
  logic             dato_valido = 1'b0;

  logic          listo, s_out, s_valido, ocupado, err_desborde;
  logic [CW-1:0] conteo;
  logic          l_listo, l_s_out, l_s_valido, l_ocupado, l_err;
  logic [CW-1:0] l_conteo;

  int total = 0;
  int bad   = 0;

  // reference model: pending words, expected bit streams, bit-cycles left for current word
  logic [WIDTH-1:0] pending[$];
  bit               exp_msb[$];
  bit               exp_lsb[$];
  int               bits_left = 0;
  bit               m_err = 0;

  ser_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .dato_in(dato_in), .dato_valido(dato_valido),
    .listo(listo), .s_out(s_out), .s_valido(s_valido), .ocupado(ocupado),
    .conteo(conteo), .err_desborde(err_desborde)
  );

  ser_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .dato_in(dato_in), .dato_valido(dato_valido),
    .listo(l_listo), .s_out(l_s_out), .s_valido(l_s_valido), .ocupado(l_ocupado),
    .conteo(l_conteo), .err_desborde(l_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: one step per rising edge, cleared by reset
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        pending.delete();
        exp_msb.delete();
        exp_lsb.delete();
        bits_left = 0;
        m_err     = 0;
      end else begin
        int  sz;
        bit  acc;
        sz  = pending.size();
        acc = dato_valido && (sz != DEPTH);
        if (dato_valido && !acc) m_err = 1;
        if (bits_left <= 1 && sz > 0) begin
          void'(pending.pop_front());
          bits_left = WIDTH;
        end else if (bits_left > 0) begin
          bits_left--;
        end
        if (acc) begin
          pending.push_back(dato_in);
          for (int i = 0; i < WIDTH; i++) begin
            exp_msb.push_back(dato_in[WIDTH-1-i]);
            exp_lsb.push_back(dato_in[i]);
          end
        end
      end
    end
  end

  // monitor: compares every cycle on the falling edge, pops expected bits when valid
  initial begin
    forever begin
      @(negedge clk);
      chk("s_valido", s_valido, bits_left > 0);
      chk("ocupado", ocupado, bits_left > 0);
      chk("conteo", conteo, pending.size());
      chk("listo", listo, rst && (pending.size() != DEPTH));
      chk("err_desborde", err_desborde, m_err);
      chk("lsb_s_valido", l_s_valido, bits_left > 0);
      chk("lsb_ocupado", l_ocupado, bits_left > 0);
      chk("lsb_conteo", l_conteo, pending.size());
      chk("lsb_listo", l_listo, rst && (pending.size() != DEPTH));
      chk("lsb_err", l_err, m_err);
      if (s_valido) begin
        if (exp_msb.size() == 0) chk("msb_unexpected_bit", 1, 0);
        else chk("msb_bit", s_out, exp_msb.pop_front());
      end else begin
        chk("msb_idle", s_out, 0);
      end
      if (l_s_valido) begin
        if (exp_lsb.size() == 0) chk("lsb_unexpected_bit", 1, 0);
        else chk("lsb_bit", l_s_out, exp_lsb.pop_front());
      end else begin
        chk("lsb_idle", l_s_out, 0);
      end
    end
  end

  // one rising edge with the given inputs; returns at edge+1
  task automatic cyc(input logic v, input logic [WIDTH-1:0] d);
    dato_valido = v;
    dato_in     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 400; i++) begin
      if (bits_left == 0 && pending.size() == 0) begin
        done = 1;
        break;
      end
      cyc(0, '0);
    end
    chk("drain_within_budget", done, 1);
    cyc(0, '0);
    cyc(0, '0);
    chk("exp_msb_empty", exp_msb.size(), 0);
    chk("exp_lsb_empty", exp_lsb.size(), 0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_s_out", s_out, 0);
    chk("rst_s_valido", s_valido, 0);
    chk("rst_conteo", conteo, 0);
    chk("rst_listo", listo, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_err", err_desborde, 0);
    @(posedge clk);
    #1;
    cyc(0, '0);
    rst = 1'b1;
    cyc(0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int guard;
    @(posedge clk);
    #1;
    do_reset();

    // single word
    cyc(1, 8'hB4);
    repeat (12) cyc(0, '0);

    // back-to-back words, no idle gap
    cyc(1, 8'hA5);
    cyc(1, 8'h3C);
    drain();

    // pointer wrap: 12 words paced by listo
    for (int w = 0; w < 12; w++) begin
      guard = 0;
      while (!listo && guard < 100) begin
        cyc(0, '0);
        guard++;
      end
      chk("wrap_listo_wait", guard < 100, 1);
      cyc(1, WIDTH'(8'h10 + w));
    end
    drain();
    chk("wrap_no_overflow", err_desborde, 0);

    // fill / overflow: words 1..6 on consecutive edges
    for (int w = 1; w <= 6; w++) cyc(1, WIDTH'(w));
    cyc(0, '0);
    chk("overflow_flag", err_desborde, 1);
    drain();

    // reset mid-word: FF in flight with two words queued
    do_reset();
    cyc(1, 8'hFF);
    cyc(1, 8'h11);
    cyc(1, 8'h22);
    repeat (3) cyc(0, '0);
    do_reset();
    repeat (12) cyc(0, '0);
    chk("post_reset_quiet", s_valido, 0);

    // randomized traffic at varying offered load
    for (int phase = 0; phase < 3; phase++) begin
      int rate;
      rate = (phase == 0) ? 10 : (phase == 1) ? 40 : 90;
      for (int i = 0; i < 300; i++) begin
        cyc($urandom_range(0, 99) < rate, WIDTH'($urandom));
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ser_tx_fifo.md
Name: ser_tx_fifo

Overview:
- Upstream stage feeding the serial input `s_in` of the sequence detector `det_sec`.
- Accepts parallel words through a valid/ready handshake and buffers them in a small FIFO.
- Emits the words one bit per clock on `s_out`, with a qualifying `s_valido` flag.
- When no data is pending, drives a fixed idle level, so the detector always sees a defined bit stream.

Parameters:
- WIDTH, 8: bits per word.
- DEPTH, 4: FIFO entries; must be a power of 2 and at least 2.
- MSB_FIRST, 1: 1 = send bit WIDTH-1 first; 0 = send bit 0 first.
- IDLE_BIT, 0: value driven on `s_out` whenever `s_valido` = 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- dato_in  input  WIDTH  parallel word to enqueue.
- dato_valido  input  1  `dato_in` is valid this cycle.
- listo  output  1  FIFO can accept a word this cycle.
- s_out  output  1  serial bit; connects to `det_sec.s_in`.
- s_valido  output  1  `s_out` carries a data bit (not idle).
- ocupado  output  1  serializer is shifting a word.
- conteo  output  $clog2(DEPTH)+1  number of words held in the FIFO, excluding the word being shifted.
- err_desborde  output  1  sticky flag: a write was attempted while `listo` = 0.

Behaviour:
- Reset (`rst` = 0, asynchronous, takes effect immediately):
  - pointers cleared, `conteo` = 0, FSM = INACTIVO;
  - `s_out` = IDLE_BIT, `s_valido` = 0, `ocupado` = 0, `err_desborde` = 0;
  - `listo` forced to 0 while `rst` = 0.
- Reset release: first rising edge with `rst` = 1 operates normally; `listo` = 1.
- `listo` = (`conteo` != DEPTH):
  - combinational from the registered count only;
  - a same-cycle pop does not raise `listo`.
- Write: accepted at a rising edge when `dato_valido` = 1 and `listo` = 1; word stored at the write pointer, pointer wraps modulo DEPTH.
- Rejected write: `dato_valido` = 1 with `listo` = 0 drops the word and sets `err_desborde` = 1. The flag stays 1 until reset.
- FSM states:
  - INACTIVO: `s_valido` = 0, `s_out` = IDLE_BIT. If `conteo` > 0 at an edge: pop the head into the shift register, drive its first bit, bit counter = WIDTH-1, go to TRANSMITE.
  - TRANSMITE: `ocupado` = 1, `s_valido` = 1; each edge advances one bit. On the edge after the last bit:
    - if `conteo` > 0: pop and load the next word with no gap cycle; stay in TRANSMITE;
    - otherwise go to INACTIVO, `s_out` = IDLE_BIT, `s_valido` = 0.
- Outputs `s_out`, `s_valido`, `ocupado` are registered; no combinational path from inputs.
- Latency: word accepted at edge E0 into an empty, idle block → first bit valid after E1, bit k valid after E(1+k), last bit after E(WIDTH).
- Push and pop at the same edge: `conteo` unchanged; both pointers advance.
- A word written at the same edge the FIFO goes empty→pop is not possible. The pop only considers the registered `conteo`, so a word arriving into an empty FIFO waits one edge.
- Bit order follows MSB_FIRST; shift direction selected at elaboration, no runtime change.
- Reset mid-word: the word being shifted and all FIFO contents are discarded; no partial word resumes.

Test Plan:
- Single word: after reset release, write 8'hB4 at E0, idle after → `s_out` = 1,0,1,1,0,1,0,0 after E1..E8 with `s_valido` = 1. After E9: `s_valido` = 0, `s_out` = 0, `ocupado` = 0.
- Back-to-back: write 8'hA5 at E0 and 8'h3C at E1 → 16 consecutive valid bits 10100101 00111100 after E1..E16, no idle gap. `conteo` = 1 after E1, 0 after E9.
- Fill/overflow: `dato_valido` = 1 for 6 consecutive edges E0..E5 with words 1..6:
  - `conteo` = 1,1,2,3,4 after E0..E4;
  - `listo` = 0 after E4; word 6 dropped, `err_desborde` = 1 after E5;
  - serial output carries words 1..5 only.
- Pointer wrap: 12 words written at `listo`-paced rate → all 12 serialized in order, `err_desborde` = 0 throughout.
- Reset mid-word: assert `rst` = 0 during bit 3 of 8'hFF with 2 words queued →
  - immediately: `s_out` = 0, `s_valido` = 0, `conteo` = 0, `listo` = 0;
  - after release: no output until a new write.
- LSB-first: MSB_FIRST = 0, write 8'h01 → `s_out` = 1,0,0,0,0,0,0,0.
